// File: rtl/mips_pkg.sv
// Shared MIPS register-file definitions: default address width, register
// address type and the hardwired-zero register index.
package mips_pkg;

  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = {DEF_ADDR_W{1'b0}};

endpackage

// File: rtl/onehot_decoder.sv
// Parametrised enable-gated address decoder: one line of 2**ADDR_W is driven
// high for the selected address, all lines low while the enable is low.
module onehot_decoder #(
  parameter int ADDR_W = mips_pkg::DEF_ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  // Select the addressed line only while enabled.
  always_comb begin
    onehot = {(2**ADDR_W){1'b0}};
    if (en) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = {(2**ADDR_W){1'b0}};
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register saturating pending-write counters
// that stall decode on RAW hazards and on pending-write overflow.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int CNT_W          = 2,
  parameter bit ZERO_HARDWIRED = 1'b1,
  parameter bit BYPASS_WB      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic [ADDR_W-1:0]    issue_rs,
  input  logic [ADDR_W-1:0]    issue_rt,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic                 rs_busy,
  output logic                 rt_busy,
  output logic                 wb_err
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] MAX_PEND = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0] inc_s;
  logic [NUM_REGS-1:0] dec_s;
  logic [NUM_REGS-1:0] busy_s;
  logic                rs_bypass_s;
  logic                rt_bypass_s;
  logic                fire_s;
  logic                wb_err_set_s;
  logic                wb_err_r;

  // Retiring the last pending write this cycle hides the hazard when bypass is enabled.
  assign rs_bypass_s = BYPASS_WB && wb_valid && (wb_rd == issue_rs) && (cnt_s[issue_rs] == CNT_ONE);
  assign rt_bypass_s = BYPASS_WB && wb_valid && (wb_rd == issue_rt) && (cnt_s[issue_rt] == CNT_ONE);

  assign rs_busy     = (cnt_s[issue_rs] != CNT_ZERO) && !rs_bypass_s;
  assign rt_busy     = (cnt_s[issue_rt] != CNT_ZERO) && !rt_bypass_s;
  assign issue_ready = !rs_busy && !rt_busy && !(issue_we && (cnt_s[issue_rd] == MAX_PEND));
  assign fire_s      = issue_valid && issue_ready;

  onehot_decoder #(.ADDR_W(ADDR_W)) u_issue_dec (
    .en     (fire_s && issue_we),
    .addr   (issue_rd),
    .onehot (inc_s)
  );

  onehot_decoder #(.ADDR_W(ADDR_W)) u_wb_dec (
    .en     (wb_valid),
    .addr   (wb_rd),
    .onehot (dec_s)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam bit TRACKED = !(ZERO_HARDWIRED && (i == 0));
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             busy_r;

    // Next pending count: flush wins, a same-cycle issue and retire cancel out.
    always_comb begin
      cnt_nxt_s = cnt_r;
      if (!TRACKED || flush) begin
        cnt_nxt_s = CNT_ZERO;
      end else if (inc_s[i] && dec_s[i]) begin
        cnt_nxt_s = cnt_r;
      end else if (inc_s[i] && (cnt_r != MAX_PEND)) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else if (dec_s[i] && (cnt_r != CNT_ZERO)) begin
        cnt_nxt_s = cnt_r - CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end

    // Counter and its busy flag are registered together from the same next value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r  <= CNT_ZERO;
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_nxt_s;
        busy_r <= (cnt_nxt_s != CNT_ZERO);
      end
    end

    assign cnt_s[i]  = cnt_r;
    assign busy_s[i] = busy_r;
  end

  // A retire with nothing outstanding is an error unless an issue to that register nets it out.
  assign wb_err_set_s = wb_valid && !flush && (cnt_s[wb_rd] == CNT_ZERO) && !inc_s[wb_rd]
                        && !(ZERO_HARDWIRED && (wb_rd == ADDR_W'(REG_ZERO)));

  // Sticky writeback error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_err_r <= 1'b0;
    end else if (wb_err_set_s) begin
      wb_err_r <= 1'b1;
    end else begin
      wb_err_r <= wb_err_r;
    end
  end

  assign busy_vec = busy_s;
  assign wb_err   = wb_err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: one bypassing and one non-bypassing
// instance share stimulus; expectations are queued as stimulus is driven.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_we, wb_valid, flush;
  logic [4:0]  issue_rd, issue_rs, issue_rt, wb_rd;
  logic        issue_ready, rs_busy, rt_busy, wb_err;
  logic [31:0] busy_vec;
  logic        nb_issue_ready, nb_rs_busy, nb_rt_busy, nb_wb_err;
  logic [31:0] nb_busy_vec;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } item_t;

  item_t exp_q[$];
  item_t res_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  localparam int S_READY = 0, S_RS = 1, S_RT = 2, S_ERR = 3, S_BV = 4, S_NB_RS = 5;

  reg_scoreboard #(.ADDR_W(5), .CNT_W(2), .ZERO_HARDWIRED(1'b1), .BYPASS_WB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy_vec(busy_vec),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .wb_err(wb_err)
  );

  reg_scoreboard #(.ADDR_W(5), .CNT_W(2), .ZERO_HARDWIRED(1'b1), .BYPASS_WB(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_ready(nb_issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy_vec(nb_busy_vec),
    .rs_busy(nb_rs_busy), .rt_busy(nb_rt_busy), .wb_err(nb_wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_READY: observe = {31'd0, issue_ready};
      S_RS:    observe = {31'd0, rs_busy};
      S_RT:    observe = {31'd0, rt_busy};
      S_ERR:   observe = {31'd0, wb_err};
      S_BV:    observe = busy_vec;
      S_NB_RS: observe = {31'd0, nb_rs_busy};
      default: observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void expect_val(string name, int sel, logic [31:0] val);
    item_t e;
    e.name = name; e.sel = sel; e.val = val;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] bit_at(int idx);
    logic [31:0] v;
    v = 32'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pair every queued expectation with the DUT value seen right now.
  task automatic sample();
    item_t e, r;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r.name = e.name; r.sel = e.sel; r.val = observe(e.sel);
      res_q.push_back(e);
      res_q.push_back(r);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_we = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    issue_rd = 5'd0; issue_rs = 5'd0; issue_rt = 5'd0; wb_rd = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    issue_valid = 1'b1; issue_we = we; issue_rd = rd; issue_rs = rs; issue_rt = rt;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1'b1; wb_rd = rd;
  endtask

  task automatic test_reset();
    item_t e, a;
    rst_n = 1'b0;
    issue(1'b1, 5'd5, 5'd3, 5'd7);
    wb(5'd9);
    expect_val("reset_ready", S_READY, 32'd1);
    expect_val("reset_rs_busy", S_RS, 32'd0);
    expect_val("reset_rt_busy", S_RT, 32'd0);
    expect_val("reset_busy_vec", S_BV, 32'd0);
    expect_val("reset_wb_err", S_ERR, 32'd0);
    @(negedge clk); sample();
    #2 rst_n = 1'b1;
    idle();
    tick();
    while (res_q.size() > 0) begin
      e = res_q.pop_front(); a = res_q.pop_front(); n_checks++;
      if (a.val !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, a.val, e.val); end
    end
  endtask

  task automatic test_basic_raw();
    item_t e, a;
    issue(1'b1, 5'd5, 5'd1, 5'd2);
    expect_val("basic_first_ready", S_READY, 32'd1);
    @(negedge clk); sample();
    tick(); idle();
    expect_val("basic_busy5", S_BV, bit_at(5));
    @(negedge clk); sample();
    tick(); issue(1'b0, 5'd0, 5'd5, 5'd0);
    expect_val("basic_rs_busy", S_RS, 32'd1);
    expect_val("basic_stall", S_READY, 32'd0);
    @(negedge clk); sample();
    tick(); idle(); wb(5'd5);
    tick(); idle();
    expect_val("basic_wb_clear", S_BV, 32'd0);
    expect_val("basic_no_err", S_ERR, 32'd0);
    @(negedge clk); sample();
    tick();
    while (res_q.size() > 0) begin
      e = res_q.pop_front(); a = res_q.pop_front(); n_checks++;
      if (a.val !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, a.val, e.val); end
    end
  endtask

  task automatic test_saturate();
    item_t e, a;
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 5'd7, 5'd0, 5'd0);
      expect_val($sformatf("sat_issue%0d_ready", k), S_READY, 32'd1);
      @(negedge clk); sample();
      tick();
    end
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    expect_val("sat_full_stall", S_READY, 32'd0);
    @(negedge clk); sample();
    tick(); idle(); wb(5'd7);
    tick(); idle();
    issue_we = 1'b1; issue_rd = 5'd7;
    expect_val("sat_after_wb_busy7", S_BV, bit_at(7));
    expect_val("sat_after_wb_ready", S_READY, 32'd1);
    @(negedge clk); sample();
    tick(); idle(); wb(5'd7);
    tick(); wb(5'd7);
    tick(); idle();
    expect_val("sat_drained", S_BV, 32'd0);
    @(negedge clk); sample();
    tick();
    while (res_q.size() > 0) begin
      e = res_q.pop_front(); a = res_q.pop_front(); n_checks++;
      if (a.val !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, a.val, e.val); end
    end
  endtask

  task automatic test_bypass();
    item_t e, a;
    issue(1'b1, 5'd9, 5'd0, 5'd0);
    tick(); idle();
    wb(5'd9);
    issue(1'b0, 5'd0, 5'd9, 5'd9);
    expect_val("byp_rs_busy", S_RS, 32'd0);
    expect_val("byp_rt_busy", S_RT, 32'd0);
    expect_val("byp_ready", S_READY, 32'd1);
    expect_val("nobyp_rs_busy", S_NB_RS, 32'd1);
    @(negedge clk); sample();
    tick(); idle();
    expect_val("byp_cleared", S_BV, 32'd0);
    @(negedge clk); sample();
    tick();
    while (res_q.size() > 0) begin
      e = res_q.pop_front(); a = res_q.pop_front(); n_checks++;
      if (a.val !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, a.val, e.val); end
    end
  endtask

  task automatic test_zero_reg();
    item_t e, a;
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    tick(); idle();
    expect_val("zero_busy_vec", S_BV, 32'd0);
    @(negedge clk); sample();
    tick(); issue(1'b1, 5'd0, 5'd0, 5'd0);
    expect_val("zero_ready", S_READY, 32'd1);
    @(negedge clk); sample();
    tick(); idle(); wb(5'd0);
    tick(); idle();
    expect_val("zero_wb_no_err", S_ERR, 32'd0);
    @(negedge clk); sample();
    tick();
    while (res_q.size() > 0) begin
      e = res_q.pop_front(); a = res_q.pop_front(); n_checks++;
      if (a.val !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, a.val, e.val); end
    end
  endtask

  task automatic test_same_cycle();
    item_t e, a;
    issue(1'b1, 5'd3, 5'd0, 5'd0);
    tick(); idle();
    issue(1'b1, 5'd3, 5'd0, 5'd0);
    wb(5'd3);
    tick(); idle();
    expect_val("same_busy3", S_BV, bit_at(3));
    expect_val("same_no_err", S_ERR, 32'd0);
    @(negedge clk); sample();
    tick(); wb(5'd3);
    tick(); idle();
    expect_val("same_drained", S_BV, 32'd0);
    expect_val("same_drain_no_err", S_ERR, 32'd0);
    @(negedge clk); sample();
    tick(); wb(5'd12);
    tick(); idle();
    expect_val("underflow_err", S_ERR, 32'd1);
    @(negedge clk); sample();
    tick(); tick();
    expect_val("underflow_err_sticky", S_ERR, 32'd1);
    @(negedge clk); sample();
    tick();
    while (res_q.size() > 0) begin
      e = res_q.pop_front(); a = res_q.pop_front(); n_checks++;
      if (a.val !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, a.val, e.val); end
    end
  endtask

  task automatic test_flush_and_async_reset();
    item_t e, a;
    issue(1'b1, 5'd4, 5'd0, 5'd0);
    tick(); issue(1'b1, 5'd20, 5'd0, 5'd0);
    tick(); idle();
    expect_val("flush_pending", S_BV, bit_at(4) | bit_at(20));
    @(negedge clk); sample();
    tick(); issue(1'b1, 5'd6, 5'd0, 5'd0); flush = 1'b1;
    tick(); idle();
    expect_val("flush_cleared", S_BV, 32'd0);
    expect_val("flush_keeps_err", S_ERR, 32'd1);
    @(negedge clk); sample();
    tick(); issue(1'b1, 5'd4, 5'd0, 5'd0);
    tick(); idle();
    expect_val("pre_reset_busy4", S_BV, bit_at(4));
    @(negedge clk); sample();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    expect_val("async_rst_err", S_ERR, 32'd0);
    expect_val("async_rst_busy", S_BV, 32'd0);
    sample();
    #3 rst_n = 1'b1;
    tick();
    while (res_q.size() > 0) begin
      e = res_q.pop_front(); a = res_q.pop_front(); n_checks++;
      if (a.val !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, a.val, e.val); end
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_basic_raw();
    test_saturate();
    test_bypass();
    test_zero_reg();
    test_same_cycle();
    test_flush_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
